// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: default register file geometry and the hardwired-zero address, shared with decode and hazard logic
package reg_file_sb_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int ZERO_ADDR      = 0;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: write-pending bits per register; flush clears all, writeback clears one, a reservation sets one (strongest)
// ports: clk, rst (async, active-low), flush, wen/waddr (release), rsv_en/rsv_addr (reserve), busy_vec (bit per register)
module rf_scoreboard import reg_file_sb_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wen,
  input  logic [ADDR_WIDTH-1:0]    waddr,
  input  logic                     rsv_en,
  input  logic [ADDR_WIDTH-1:0]    rsv_addr,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);
  logic [2**ADDR_WIDTH-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = flush ? '0 : busy_q;
    if (wen) busy_d[waddr] = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[ZERO_ADDR] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) busy_q <= '0;
    else busy_q <= busy_d;
  assign busy_vec = busy_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write-pending scoreboard and same-cycle write-through bypass
// ports: clk, rst (async, active-low); raddr/rdata/rbusy packed per read port; wen/waddr/wdata writeback;
//        rsv_en/rsv_addr reservation at issue; flush clears reservations; busy_vec raw scoreboard bits
module reg_file_sb import reg_file_sb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  input  logic                         flush,
  output logic [2**ADDR_WIDTH-1:0]     busy_vec
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZA = ADDR_WIDTH'(ZERO_ADDR);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic wr_ok;
  // writes to the hardwired zero register are dropped, so they neither store nor forward
  assign wr_ok = wen && !(ZERO_REG != 0 && waddr == ZA);
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  rf_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .waddr(waddr),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic hit, zero;
    assign ra   = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit  = (BYPASS != 0) && wr_ok && waddr == ra;
    assign zero = (ZERO_REG != 0) && ra == ZA;
    assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = zero ? '0 : hit ? wdata : mem_q[ra];
    // the writeback being forwarded is the producer the reader waits on, so it is no longer busy
    assign rbusy[i] = hit ? 1'b0 : busy_vec[ra];
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks on the default and no-bypass builds, plus model-checked traffic on a wide/shallow build
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [9:0]  raddr = '0;
  logic [63:0] rdata, rdata_nb;
  logic [1:0]  rbusy, rbusy_nb;
  logic        wen = 1'b0, rsv_en = 1'b0, flush = 1'b0;
  logic [4:0]  waddr = '0, rsv_addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] busy_vec, busy_vec_nb;
  logic [11:0]  p_raddr = '0;
  logic [191:0] p_rdata;
  logic [2:0]   p_rbusy;
  logic         p_wen = 1'b0, p_rsv_en = 1'b0, p_flush = 1'b0;
  logic [3:0]   p_waddr = '0, p_rsv_addr = '0;
  logic [63:0]  p_wdata = '0;
  logic [15:0]  p_busy_vec;
  logic [63:0]  m_mem [16];
  logic [15:0]  m_busy;
  reg_file_sb dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .wen(wen), .waddr(waddr),
    .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec)
  );
  reg_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb), .wen(wen), .waddr(waddr),
    .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_nb)
  );
  reg_file_sb #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_RD(3), .ZERO_REG(0)) dut_p (
    .clk(clk), .rst(rst), .raddr(p_raddr), .rdata(p_rdata), .rbusy(p_rbusy), .wen(p_wen), .waddr(p_waddr),
    .wdata(p_wdata), .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr), .flush(p_flush), .busy_vec(p_busy_vec)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    raddr = {a1, a0};
    #1;
  endtask
  task automatic idle();
    wen = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask
  task automatic p_check(input int cyc);
    logic [3:0] a;
    logic hit;
    for (int k = 0; k < 3; k++) begin
      a = p_raddr[k*4 +: 4];
      hit = p_wen && p_waddr == a;
      chk($sformatf("sweep_data c%0d p%0d", cyc, k), p_rdata[k*64 +: 64], hit ? p_wdata : m_mem[a]);
      chk($sformatf("sweep_busy c%0d p%0d", cyc, k), {63'd0, p_rbusy[k]}, {63'd0, hit ? 1'b0 : m_busy[a]});
    end
    chk($sformatf("sweep_vec c%0d", cyc), {48'd0, p_busy_vec}, {48'd0, m_busy});
  endtask
  task automatic p_commit();
    if (p_flush) m_busy = '0;
    if (p_wen) begin
      m_mem[p_waddr] = p_wdata;
      m_busy[p_waddr] = 1'b0;
    end
    if (p_rsv_en) m_busy[p_rsv_addr] = 1'b1;
  endtask
  initial begin
    for (int k = 0; k < 16; k++) m_mem[k] = '0;
    m_busy = '0;
    #12;
    rst = 1'b1;
    #3;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk($sformatf("reset_rd x%0d", a), {rbusy, rdata}, 66'd0);
    end
    chk("reset_vec", {32'd0, busy_vec}, 64'd0);
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    idle(); rd(5, 5);
    chk("wr_x5", rdata, 64'hDEADBEEF_DEADBEEF);
    wen = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    rd(0, 0);
    chk("x0_bypass_blocked", rdata, 64'd0);
    step();
    idle(); rd(0, 5);
    chk("x0_after_wr", rdata, {32'hDEADBEEF, 32'd0});
    wen = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
    step();
    wdata = 32'hA5A5A5A5; rd(7, 5);
    chk("bypass_on", rdata[31:0], 64'hA5A5A5A5);
    chk("bypass_off", rdata_nb[31:0], 64'h11111111);
    step();
    idle(); rd(7, 7);
    chk("bypass_commit", rdata_nb, 64'hA5A5A5A5_A5A5A5A5);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    idle(); rd(3, 3);
    chk("rsv_x3", {30'd0, rbusy, busy_vec}, {32'd3, 32'h8});
    wen = 1'b1; waddr = 5'd3; wdata = 32'h33; #1;
    chk("wb_rbusy_bypass", {62'd0, rbusy}, 64'd0);
    chk("wb_rbusy_nobypass", {62'd0, rbusy_nb}, 64'd3);
    step();
    idle(); rd(3, 3);
    chk("wb_done", {30'd0, rbusy, busy_vec}, 64'd0);
    chk("wb_data", rdata, 64'h33_00000033);
    rsv_en = 1'b1; rsv_addr = 5'd9; wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    step();
    idle(); rd(9, 3);
    chk("collide_vec", {32'd0, busy_vec}, 64'h200);
    chk("collide_data", {31'd0, rbusy, rdata[31:0]}, {31'd0, 2'b01, 32'h99});
    rsv_en = 1'b1; rsv_addr = 5'd1;
    step();
    rsv_addr = 5'd2;
    step();
    flush = 1'b1; rsv_addr = 5'd4; wen = 1'b1; waddr = 5'd10; wdata = 32'hF10;
    step();
    idle(); rd(10, 4);
    chk("flush_rsv_vec", {32'd0, busy_vec}, 64'h10);
    chk("flush_wb_data", {rbusy, rdata[31:0]}, {2'b10, 32'hF10});
    rsv_en = 1'b1; rsv_addr = 5'd0;
    step();
    idle(); rd(0, 4);
    chk("rsv_x0", {30'd0, rbusy, busy_vec}, {32'd2, 32'h10});
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    idle(); #1;
    chk("rersv_x4", {32'd0, busy_vec}, 64'h10);
    wen = 1'b1; waddr = 5'd4; wdata = 32'h44;
    step();
    idle(); rd(4, 5);
    chk("rersv_single_wb", {30'd0, rbusy, busy_vec}, 64'd0);
    rsv_en = 1'b1; rsv_addr = 5'd6;
    step();
    idle();
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_data", rdata, 64'd0);
    chk("mid_reset_busy", {30'd0, rbusy, busy_vec}, 64'd0);
    #2 rst = 1'b1;
    wen = 1'b1; waddr = 5'd5; wdata = 32'hCAFE;
    step();
    idle(); rd(5, 4);
    chk("post_reset_wr", rdata, 64'h0_0000CAFE);
    p_wen = 1'b1; p_waddr = 4'd0; p_wdata = 64'h0123456789ABCDEF;
    p_rsv_en = 1'b1; p_rsv_addr = 4'd0; p_raddr = 12'h000; #1;
    p_check(-1);
    p_commit();
    step();
    p_wen = 1'b0; p_rsv_en = 1'b0; #1;
    p_check(0);
    for (int c = 1; c <= 200; c++) begin
      p_wen = 1'($urandom_range(0, 1));
      p_waddr = 4'($urandom);
      p_wdata = {$urandom, $urandom};
      p_rsv_en = 1'($urandom_range(0, 1));
      p_rsv_addr = 4'($urandom);
      p_flush = ($urandom_range(0, 15) == 0);
      p_raddr = 12'($urandom);
      if (c % 5 == 0) p_raddr[3:0] = p_waddr;
      #1;
      p_check(c);
      p_commit();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
